// File: rtl/cpu31_wb_pkg.sv
// Shared types and sizes for the register-file writeback path.
package cpu31_wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  // One queued register-file write: destination plus data.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] waddr;
    logic [DATA_W-1:0]     wdata;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO for pending register-file writes.
// The head entry is presented directly from the storage registers, so a push
// becomes visible on the cycle after it is accepted (no same-cycle bypass).
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head_data = mem_reg[rd_ptr_reg[AW-1:0]];

  // Storage is cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (do_push) begin
      mem_reg[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  // Read/write pointers advance independently on accepted push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/wb_write_ctrl.sv
// Writer side of the 32x32 register-file write port.
// Queues producer results, drains one write per cycle, and tracks a
// per-register pending-write count so issue logic can stall on RAW hazards.
module wb_write_ctrl
  import cpu31_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_waddr,
  output logic                  iss_ready,
  input  logic                  res_valid,
  output logic                  res_ready,
  input  logic [REG_ADDR_W-1:0] res_waddr,
  input  logic [DATA_W-1:0]     res_wdata,
  input  logic                  res_overflow,
  input  logic                  wb_hold,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  input  logic [REG_ADDR_W-1:0] chk_raddr1,
  input  logic [REG_ADDR_W-1:0] chk_raddr2,
  output logic                  chk_busy1,
  output logic                  chk_busy2,
  output logic                  err_sticky
);

  logic [NUM_REGS-1:0][CNT_W-1:0] count_reg;
  logic [NUM_REGS-1:0][CNT_W-1:0] count_next;
  logic [NUM_REGS-1:0]            underflow;
  logic                           err_reg;

  logic      fifo_full;
  logic      fifo_empty;
  logic      accept;
  logic      keep;
  logic      push;
  logic      drop_retire;
  logic      iss_fire;
  wb_entry_t push_entry;
  wb_entry_t head_entry;

  // Result acceptance: $zero and overflowed results are dropped, but a
  // dropped overflow still retires its reservation.
  assign res_ready   = !fifo_full;
  assign accept      = res_valid && res_ready;
  assign keep        = (res_waddr != '0) && !res_overflow;
  assign push        = accept && keep;
  assign drop_retire = accept && !keep && (res_waddr != '0);

  assign push_entry.waddr = res_waddr;
  assign push_entry.wdata = res_wdata;

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (rf_we),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Every write that reaches the regfile pops the head in the same cycle.
  assign rf_we    = !fifo_empty && !wb_hold;
  assign rf_waddr = head_entry.waddr;
  assign rf_wdata = head_entry.wdata;

  // Reservations to $zero are accepted but never counted.
  assign iss_ready = (iss_waddr == '0) || (count_reg[iss_waddr] != {CNT_W{1'b1}});
  assign iss_fire  = iss_valid && iss_ready && (iss_waddr != '0);

  // Hazard queries see the count from before this edge.
  assign chk_busy1 = (chk_raddr1 != '0) && (count_reg[chk_raddr1] != '0);
  assign chk_busy2 = (chk_raddr2 != '0) && (count_reg[chk_raddr2] != '0);

  assign err_sticky = err_reg;

  // Per-register next count: +1 on reservation, -1 for each retire
  // (drop and pop may both hit the same register), clamped at zero.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : gen_cnt
    logic             inc;
    logic [1:0]       dec;
    logic [CNT_W:0]   sum;

    assign inc = iss_fire && (iss_waddr == REG_ADDR_W'(gi));
    assign dec = {1'b0, drop_retire && (res_waddr == REG_ADDR_W'(gi))} +
                 {1'b0, rf_we && (rf_waddr == REG_ADDR_W'(gi))};
    assign sum = {1'b0, count_reg[gi]} + {{CNT_W{1'b0}}, inc};
    assign underflow[gi]  = (sum < (CNT_W+1)'(dec));
    assign count_next[gi] = underflow[gi] ? '0 : CNT_W'(sum - (CNT_W+1)'(dec));
  end

  // Pending-write counters for all registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // Latch any retire against a register with nothing pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else if (|underflow) begin
      err_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_write_ctrl.sv
// Self-checking bench for wb_write_ctrl: table of single-cycle hazard vectors
// plus hand-written hold/full, error and reset sequences. Expected writes are
// queued when a result is offered and compared when the regfile port fires.
module tb_wb_write_ctrl;
  import cpu31_wb_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_valid;
  logic [4:0]  iss_waddr;
  logic        iss_ready;
  logic        res_valid;
  logic        res_ready;
  logic [4:0]  res_waddr;
  logic [31:0] res_wdata;
  logic        res_overflow;
  logic        wb_hold;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  chk_raddr1;
  logic [4:0]  chk_raddr2;
  logic        chk_busy1;
  logic        chk_busy2;
  logic        err_sticky;

  wb_write_ctrl #(.DEPTH(DEPTH), .CNT_W(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .iss_valid    (iss_valid),
    .iss_waddr    (iss_waddr),
    .iss_ready    (iss_ready),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_waddr    (res_waddr),
    .res_wdata    (res_wdata),
    .res_overflow (res_overflow),
    .wb_hold      (wb_hold),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .chk_raddr1   (chk_raddr1),
    .chk_raddr2   (chk_raddr2),
    .chk_busy1    (chk_busy1),
    .chk_busy2    (chk_busy2),
    .err_sticky   (err_sticky)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        iss_v;
    logic [4:0]  iss_a;
    logic        res_v;
    logic [4:0]  res_a;
    logic [31:0] res_d;
    logic        ovf;
    logic [4:0]  chk_a;
    logic        exp_rdy;
    logic        exp_busy;
  } vec_t;

  localparam int NVEC = 22;
  vec_t        vecs [NVEC];
  logic [36:0] exp_q [$];
  int          checks = 0;
  int          fails  = 0;
  logic        cyc_we;

  function automatic vec_t mkv(input logic iv, input logic [4:0] ia, input logic rv,
                               input logic [4:0] ra, input logic [31:0] rd, input logic ov,
                               input logic [4:0] ca, input logic er, input logic eb);
    vec_t v;
    v.iss_v = iv; v.iss_a = ia; v.res_v = rv; v.res_a = ra; v.res_d = rd;
    v.ovf = ov; v.chk_a = ca; v.exp_rdy = er; v.exp_busy = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    iss_valid = 1'b0; iss_waddr = '0;
    res_valid = 1'b0; res_waddr = '0; res_wdata = '0; res_overflow = 1'b0;
    chk_raddr1 = '0; chk_raddr2 = '0;
  endtask

  // Called at the drive point (posedge+1): record an accepted result, check the
  // write port at the negedge, then return at the next drive point.
  task automatic tick();
    logic [36:0] e;
    if (res_valid && res_ready && res_waddr != 5'd0 && !res_overflow)
      exp_q.push_back({res_waddr, res_wdata});
    @(negedge clk);
    cyc_we = rf_we;
    if (rf_we) begin
      chk("wr_addr_nonzero", {31'b0, rf_waddr != 5'd0}, 32'd1);
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h, required no write", rf_waddr, rf_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", {27'b0, rf_waddr}, {27'b0, e[36:32]});
        chk("wr_data", rf_wdata, e[31:0]);
        $display("write r%0d = 0x%0h", rf_waddr, rf_wdata);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Hazard table: each row is one cycle; iss_ready/busy reflect pre-edge state.
    vecs[0]  = mkv(1, 5, 0, 0, 0,          0, 5, 1, 0);
    vecs[1]  = mkv(1, 6, 0, 0, 0,          0, 5, 1, 1);
    vecs[2]  = mkv(0, 0, 1, 5, 32'h11,     0, 6, 1, 1);
    vecs[3]  = mkv(0, 0, 1, 6, 32'h22,     0, 5, 1, 1);
    vecs[4]  = mkv(0, 0, 0, 0, 0,          0, 6, 1, 1);
    vecs[5]  = mkv(0, 0, 0, 0, 0,          0, 6, 1, 0);
    vecs[6]  = mkv(1, 8, 0, 0, 0,          0, 8, 1, 0);
    vecs[7]  = mkv(0, 0, 1, 8, 32'hDEAD,   1, 8, 1, 1);
    vecs[8]  = mkv(0, 0, 0, 0, 0,          0, 8, 1, 0);
    vecs[9]  = mkv(1, 0, 1, 0, 32'h5,      0, 0, 1, 0);
    vecs[10] = mkv(0, 0, 0, 0, 0,          0, 0, 1, 0);
    vecs[11] = mkv(1, 7, 0, 0, 0,          0, 7, 1, 0);
    vecs[12] = mkv(0, 0, 1, 7, 32'h77,     0, 7, 1, 1);
    vecs[13] = mkv(1, 7, 0, 0, 0,          0, 7, 1, 1);
    vecs[14] = mkv(0, 0, 0, 0, 0,          0, 7, 1, 1);
    vecs[15] = mkv(0, 0, 1, 7, 32'h78,     0, 7, 1, 1);
    vecs[16] = mkv(0, 0, 0, 0, 0,          0, 7, 1, 1);
    vecs[17] = mkv(0, 0, 0, 0, 0,          0, 7, 1, 0);
    vecs[18] = mkv(1, 3, 0, 0, 0,          0, 3, 1, 0);
    vecs[19] = mkv(1, 3, 0, 0, 0,          0, 3, 1, 1);
    vecs[20] = mkv(1, 3, 0, 0, 0,          0, 3, 1, 1);
    vecs[21] = mkv(1, 3, 0, 0, 0,          0, 3, 0, 1);

    // Reset state
    rst_n = 1'b0;
    wb_hold = 1'b0;
    idle();
    #1;
    chk("rst_rf_we", {31'b0, rf_we}, 32'd0);
    chk("rst_rf_waddr", {27'b0, rf_waddr}, 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_err", {31'b0, err_sticky}, 32'd0);
    chk("rst_res_ready", {31'b0, res_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table-driven hazard / drop / saturation vectors
    for (int i = 0; i < NVEC; i++) begin
      iss_valid = vecs[i].iss_v; iss_waddr = vecs[i].iss_a;
      res_valid = vecs[i].res_v; res_waddr = vecs[i].res_a;
      res_wdata = vecs[i].res_d; res_overflow = vecs[i].ovf;
      chk_raddr1 = vecs[i].chk_a; chk_raddr2 = vecs[i].chk_a;
      #1;
      $display("vec %0d: iss_ready=%0b busy=%0b", i, iss_ready, chk_busy1);
      chk($sformatf("vec%0d_iss_ready", i), {31'b0, iss_ready}, {31'b0, vecs[i].exp_rdy});
      chk($sformatf("vec%0d_busy1", i), {31'b0, chk_busy1}, {31'b0, vecs[i].exp_busy});
      chk($sformatf("vec%0d_busy2", i), {31'b0, chk_busy2}, {31'b0, vecs[i].exp_busy});
      tick();
    end
    idle();
    repeat (2) tick();
    chk("after_table_err", {31'b0, err_sticky}, 32'd0);
    chk("after_table_queue", exp_q.size(), 32'd0);

    // Hold/full: reserve r10..r14, then offer DEPTH+1 results under hold
    for (int i = 0; i < 5; i++) begin
      iss_valid = 1'b1; iss_waddr = 5'(10 + i);
      #1;
      chk("hold_iss_ready", {31'b0, iss_ready}, 32'd1);
      tick();
    end
    idle();
    wb_hold = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      res_valid = 1'b1; res_waddr = 5'(10 + i); res_wdata = 32'hA0 + 32'(i);
      #1;
      chk("hold_res_ready", {31'b0, res_ready}, (i < DEPTH) ? 32'd1 : 32'd0);
      tick();
      chk("hold_no_we", {31'b0, cyc_we}, 32'd0);
    end
    res_valid = 1'b0;
    wb_hold = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      chk("drain_we", {31'b0, cyc_we}, 32'd1);
    end
    tick();
    chk("drain_done_we", {31'b0, cyc_we}, 32'd0);
    res_valid = 1'b1; res_waddr = 5'd14; res_wdata = 32'hA4;
    #1;
    chk("retry_res_ready", {31'b0, res_ready}, 32'd1);
    tick();
    idle();
    tick();
    chk("retry_we", {31'b0, cyc_we}, 32'd1);
    tick();
    chk("hold_err", {31'b0, err_sticky}, 32'd0);
    chk("hold_queue", exp_q.size(), 32'd0);

    // Retire to a register never reserved: still written, error latched
    res_valid = 1'b1; res_waddr = 5'd9; res_wdata = 32'h99;
    tick();
    idle();
    tick();
    chk("err_write_we", {31'b0, cyc_we}, 32'd1);
    chk("err_sticky_set", {31'b0, err_sticky}, 32'd1);

    // Reset mid-stream with three writes queued under hold
    wb_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iss_valid = 1'b1; iss_waddr = 5'(20 + i);
      tick();
    end
    iss_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      res_valid = 1'b1; res_waddr = 5'(20 + i); res_wdata = 32'hC0 + 32'(i);
      tick();
    end
    idle();
    chk_raddr1 = 5'd20; chk_raddr2 = 5'd21;
    #1;
    chk("pre_rst_busy1", {31'b0, chk_busy1}, 32'd1);
    chk("pre_rst_queued", exp_q.size(), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("midrst_rf_we", {31'b0, rf_we}, 32'd0);
    chk("midrst_busy1", {31'b0, chk_busy1}, 32'd0);
    chk("midrst_busy2", {31'b0, chk_busy2}, 32'd0);
    chk("midrst_err", {31'b0, err_sticky}, 32'd0);
    chk("midrst_res_ready", {31'b0, res_ready}, 32'd1);
    exp_q.delete();
    wb_hold = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_no_we", {31'b0, cyc_we}, 32'd0);
    end
    chk("post_rst_err", {31'b0, err_sticky}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
